weight_tile_loader: RTL and testbench

- Parametrised successor to the single-tile weight fill control. Streams convolution weights from an external synchronous weight memory and assembles them into ROWS x COLS tiles for the systolic array.
- Filter count may exceed COLS and kernel element count (K*K) may exceed ROWS; the block emits successive tiles over a valid/ready handshake.
- Memory read latency is configurable and handled by a pipelined fetch: one read per cycle, with the row/column tag travelling alongside each read.

---
 rtl/weight_tile_loader_pkg.sv | 23 ++
 rtl/weight_tile_loader_tag_pipe.sv | 28 ++
 rtl/weight_tile_loader.sv | 206 ++++++++++++++++++++
 tb/tb_weight_tile_loader.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_tile_loader_pkg.sv
// Shared types and helpers for the weight tile loader.
package weight_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FETCH,
    DRAIN,
    PRESENT,
    DONE
  } state_t;

  // Width of an index field able to address n positions (at least 1 bit).
  function automatic int unsigned tag_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Integer ceiling division, used for tile counts.
  function automatic int unsigned ceil_div(input int unsigned a, input int unsigned b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/weight_tile_loader_tag_pipe.sv
// Fixed-depth delay line carrying the {en, row, col} tag of each weight read.
module read_tag_pipe #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] tag_in,
  output logic [W-1:0] tag_out
);

  logic [DEPTH-1:0][W-1:0] stage_q;

  // Shift the tag one stage per cycle; reset drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= tag_in;
      for (int i = 1; i < int'(DEPTH); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign tag_out = stage_q[DEPTH-1];

endmodule

// File: rtl/weight_tile_loader.sv
// Streams weights from a synchronous memory into ROWS x COLS tiles with a valid/ready handoff.
module weight_tile_loader
  import weight_loader_pkg::*;
#(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned ROWS         = 9,
  parameter int unsigned COLS         = 9,
  parameter int unsigned DIM_W        = 16,
  parameter int unsigned ADDR_W       = 15,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [ADDR_W-1:0]             base_addr,
  input  logic [DIM_W-1:0]              weight_size,
  input  logic [DIM_W-1:0]              number_filters,
  output logic                          mem_en,
  output logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_data,
  output logic [DATA_W*ROWS*COLS-1:0]   tile_out,
  output logic                          tile_valid,
  input  logic                          tile_ready,
  output logic [DIM_W-1:0]              tile_filter_base,
  output logic [2*DIM_W-1:0]            tile_elem_base,
  output logic                          tile_last,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned RW   = tag_w(ROWS);
  localparam int unsigned CW   = tag_w(COLS);
  localparam int unsigned EW   = 2 * DIM_W;
  localparam int unsigned FBW  = DIM_W + 1;
  localparam int unsigned EBW  = EW + 1;
  localparam int unsigned DCW  = tag_w(READ_LATENCY + 1);
  localparam int unsigned TAGW = 1 + RW + CW;

  state_t                              state;
  logic [ADDR_W-1:0]                   base_q;
  logic [DIM_W-1:0]                    f_q;
  logic [EW-1:0]                       e_q;
  logic [FBW-1:0]                      fb_q;
  logic [EBW-1:0]                      eb_q;
  logic [RW-1:0]                       cnt_r;
  logic [CW-1:0]                       cnt_c;
  logic [DCW-1:0]                      drain_cnt;
  logic [RW-1:0]                       iss_r;
  logic [CW-1:0]                       iss_c;
  logic [ROWS-1:0][COLS-1:0][DATA_W-1:0] tile_q;

  logic [FBW-1:0]  filt_c;
  logic [EBW-1:0]  elem_c;
  logic            rd_en_c;
  logic            last_c;
  logic            more_elems_c;
  logic [TAGW-1:0] tag_d;
  logic            tag_en;
  logic [RW-1:0]   tag_r;
  logic [CW-1:0]   tag_c;

  // Filter/element indices of the current walk position and tile bookkeeping.
  always_comb begin
    filt_c       = fb_q + FBW'(cnt_c);
    elem_c       = eb_q + EBW'(cnt_r);
    rd_en_c      = (filt_c < FBW'(f_q)) && (elem_c < EBW'(e_q));
    last_c       = ((fb_q + FBW'(COLS)) >= FBW'(f_q)) && ((eb_q + EBW'(ROWS)) >= EBW'(e_q));
    more_elems_c = (eb_q + EBW'(ROWS)) < EBW'(e_q);
  end

  // Control FSM: walks each tile, issues reads, then presents it until accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state            <= IDLE;
      base_q           <= '0;
      f_q              <= '0;
      e_q              <= '0;
      fb_q             <= '0;
      eb_q             <= '0;
      cnt_r            <= '0;
      cnt_c            <= '0;
      drain_cnt        <= '0;
      iss_r            <= '0;
      iss_c            <= '0;
      mem_en           <= 1'b0;
      mem_addr         <= '0;
      tile_valid       <= 1'b0;
      tile_filter_base <= '0;
      tile_elem_base   <= '0;
      tile_last        <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
    end else begin
      mem_en <= 1'b0;
      done   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            base_q <= base_addr;
            f_q    <= number_filters;
            e_q    <= EW'(weight_size) * EW'(weight_size);
            fb_q   <= '0;
            eb_q   <= '0;
            busy   <= 1'b1;
            if ((weight_size == '0) || (number_filters == '0)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= CLEAR;
            end
          end
        end
        CLEAR: begin
          cnt_r <= '0;
          cnt_c <= '0;
          state <= FETCH;
        end
        FETCH: begin
          mem_en <= rd_en_c;
          iss_r  <= cnt_r;
          iss_c  <= cnt_c;
          if (rd_en_c) begin
            mem_addr <= base_q + ADDR_W'(filt_c) * ADDR_W'(e_q) + ADDR_W'(elem_c);
          end
          if (cnt_c == CW'(COLS - 1)) begin
            cnt_c <= '0;
            if (cnt_r == RW'(ROWS - 1)) begin
              cnt_r     <= '0;
              drain_cnt <= '0;
              state     <= DRAIN;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end else begin
            cnt_c <= cnt_c + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_cnt == DCW'(READ_LATENCY)) begin
            state            <= PRESENT;
            tile_valid       <= 1'b1;
            tile_filter_base <= DIM_W'(fb_q);
            tile_elem_base   <= EW'(eb_q);
            tile_last        <= last_c;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        PRESENT: begin
          if (tile_ready) begin
            tile_valid <= 1'b0;
            if (last_c) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= CLEAR;
              if (more_elems_c) begin
                eb_q <= eb_q + EBW'(ROWS);
              end else begin
                eb_q <= '0;
                fb_q <= fb_q + FBW'(COLS);
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign tag_d = {mem_en, iss_r, iss_c};

  read_tag_pipe #(
    .DEPTH (READ_LATENCY),
    .W     (TAGW)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_d),
    .tag_out ({tag_en, tag_r, tag_c})
  );

  // Tile register: zeroed per tile (padding), then filled by tagged read data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tile_q <= '0;
    end else if (state == CLEAR) begin
      tile_q <= '0;
    end else if (tag_en) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          if ((tag_r == RW'(r)) && (tag_c == CW'(c))) begin
            tile_q[r][c] <= mem_data;
          end
        end
      end
    end
  end

  assign tile_out = tile_q;

endmodule

// File: tb/tb_weight_tile_loader.sv
// Directed bench for weight_tile_loader: two instances (read latency 1 and 3).
module tb_weight_tile_loader;
  import weight_loader_pkg::*;

  localparam int DW   = 16;
  localparam int R    = 3;
  localparam int C    = 3;
  localparam int DIMW = 16;
  localparam int AW   = 15;
  localparam int TW   = DW * R * C;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic            start_a = 1'b0, start_b = 1'b0;
  logic [AW-1:0]   base_a = '0, base_b = '0;
  logic [DIMW-1:0] k_a = '0, k_b = '0, f_a = '0, f_b = '0;
  logic            mem_en_a, mem_en_b;
  logic [AW-1:0]   mem_addr_a, mem_addr_b;
  logic [DW-1:0]   mem_data_a = '0;
  logic [DW-1:0]   mem_data_b;
  logic [DW-1:0]   pipe_b [3];
  logic [TW-1:0]   tile_a, tile_b;
  logic            valid_a, valid_b, ready_a = 1'b1, ready_b = 1'b1;
  logic [DIMW-1:0] fb_a, fb_b;
  logic [2*DIMW-1:0] eb_a, eb_b;
  logic            last_a, last_b, busy_a, busy_b, done_a, done_b;

  weight_tile_loader #(.DATA_W(DW), .ROWS(R), .COLS(C), .DIM_W(DIMW), .ADDR_W(AW), .READ_LATENCY(1)) u_dut (
    .clk(clk), .reset(reset), .start(start_a), .base_addr(base_a), .weight_size(k_a),
    .number_filters(f_a), .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
    .tile_out(tile_a), .tile_valid(valid_a), .tile_ready(ready_a), .tile_filter_base(fb_a),
    .tile_elem_base(eb_a), .tile_last(last_a), .busy(busy_a), .done(done_a));

  weight_tile_loader #(.DATA_W(DW), .ROWS(R), .COLS(C), .DIM_W(DIMW), .ADDR_W(AW), .READ_LATENCY(3)) u_dut3 (
    .clk(clk), .reset(reset), .start(start_b), .base_addr(base_b), .weight_size(k_b),
    .number_filters(f_b), .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
    .tile_out(tile_b), .tile_valid(valid_b), .tile_ready(ready_b), .tile_filter_base(fb_b),
    .tile_elem_base(eb_b), .tile_last(last_b), .busy(busy_b), .done(done_b));

  // Weight memories: mem[a] = a + 1, latency 1 and 3.
  always @(posedge clk) if (mem_en_a) mem_data_a <= DW'(mem_addr_a) + 16'd1;
  always @(posedge clk) begin
    if (mem_en_b) pipe_b[0] <= DW'(mem_addr_b) + 16'd1;
    pipe_b[1] <= pipe_b[0];
    pipe_b[2] <= pipe_b[1];
  end
  assign mem_data_b = pipe_b[2];

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [TW-1:0] tiles [2][8];
  int  tfb [2][8];
  int  teb [2][8];
  bit  tlast [2][8];
  int  ntiles [2], nreads [2], ndone [2], nvalid [2], bad_en [2], fv [2], edge0 [2];

  // Monitors: record accepted tiles, reads, done pulses, first tile_valid cycle.
  always @(negedge clk) begin
    if (valid_a && ready_a && ntiles[0] < 8) begin
      tiles[0][ntiles[0]] = tile_a; tfb[0][ntiles[0]] = int'(fb_a);
      teb[0][ntiles[0]] = int'(eb_a); tlast[0][ntiles[0]] = last_a; ntiles[0]++;
    end
    if (valid_a && fv[0] < 0) fv[0] = cyc - edge0[0];
    if (valid_a) nvalid[0]++;
    if (mem_en_a) nreads[0]++;
    if (done_a) ndone[0]++;
    if (mem_en_a && (valid_a || done_a || !busy_a)) bad_en[0]++;
  end
  always @(negedge clk) begin
    if (valid_b && ready_b && ntiles[1] < 8) begin
      tiles[1][ntiles[1]] = tile_b; tfb[1][ntiles[1]] = int'(fb_b);
      teb[1][ntiles[1]] = int'(eb_b); tlast[1][ntiles[1]] = last_b; ntiles[1]++;
    end
    if (valid_b && fv[1] < 0) fv[1] = cyc - edge0[1];
    if (valid_b) nvalid[1]++;
    if (mem_en_b) nreads[1]++;
    if (done_b) ndone[1]++;
    if (mem_en_b && (valid_b || done_b || !busy_b)) bad_en[1]++;
  end

  typedef struct { int run; int tile; int r; int c; int val; } spot_t;
  typedef struct { int run; int tile; int fb; int eb; int last; } meta_t;
  spot_t spots [$];
  meta_t metas [$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] elem(input logic [TW-1:0] t, input int r, input int c);
    return t[(r*C + c)*DW +: DW];
  endfunction

  // Reference weight for tile entry (r,c) at tile origin (fb, eb).
  function automatic logic [DW-1:0] model(input int base, input int k, input int f,
                                          input int fb, input int eb, input int r, input int c);
    int e;
    e = k * k;
    if ((fb + c < f) && (eb + r < e)) return DW'(((base + (fb + c) * e + eb + r) % 32768) + 1);
    return '0;
  endfunction

  task automatic clear_counts(input int d);
    ntiles[d] = 0; nreads[d] = 0; ndone[d] = 0; nvalid[d] = 0; bad_en[d] = 0; fv[d] = -1;
  endtask

  task automatic start_load(input int d, input int base, input int k, input int f);
    clear_counts(d);
    if (d == 0) begin base_a = AW'(base); k_a = DIMW'(k); f_a = DIMW'(f); start_a = 1'b1; end
    else begin base_b = AW'(base); k_b = DIMW'(k); f_b = DIMW'(f); start_b = 1'b1; end
    tick();
    edge0[d] = cyc;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic wait_done(input int d, input int budget);
    int i;
    i = 0;
    while (i < budget && !(ndone[d] > 0 && ((d == 0) ? !busy_a : !busy_b))) begin
      tick();
      i++;
    end
    check($sformatf("done_within_budget_dut%0d", d), 64'(ndone[d] > 0), 64'd1);
  endtask

  // Compare every captured tile against the reference model and tile order.
  task automatic check_tiles(input int d, input string name, input int base, input int k, input int f);
    int e, ne, nf, bad;
    e  = k * k;
    ne = int'(ceil_div(e, R));
    nf = int'(ceil_div(f, C));
    check({name, "_ntiles"}, 64'(ntiles[d]), 64'(nf * ne));
    for (int t = 0; t < ntiles[d]; t++) begin
      bad = 0;
      for (int r = 0; r < R; r++)
        for (int c = 0; c < C; c++)
          if (elem(tiles[d][t], r, c) !== model(base, k, f, (t / ne) * C, (t % ne) * R, r, c)) bad++;
      check($sformatf("%s_t%0d_data_errs", name, t), 64'(bad), 64'd0);
      check($sformatf("%s_t%0d_fbase", name, t), 64'(tfb[d][t]), 64'((t / ne) * C));
      check($sformatf("%s_t%0d_ebase", name, t), 64'(teb[d][t]), 64'((t % ne) * R));
      check($sformatf("%s_t%0d_last", name, t), 64'(tlast[d][t]), 64'(t == nf * ne - 1));
    end
    check({name, "_reads"}, 64'(nreads[d]), 64'(f * e));
    check({name, "_done_pulses"}, 64'(ndone[d]), 64'd1);
    check({name, "_bad_mem_en"}, 64'(bad_en[d]), 64'd0);
  endtask

  // Hand-computed spot values and tile metadata for one run.
  task automatic apply_table(input int run, input int d);
    foreach (spots[i]) if (spots[i].run == run) begin
      if (spots[i].tile < ntiles[d])
        check($sformatf("spot_run%0d_t%0d_r%0d_c%0d", run, spots[i].tile, spots[i].r, spots[i].c),
              64'(elem(tiles[d][spots[i].tile], spots[i].r, spots[i].c)), 64'(spots[i].val));
      else
        check($sformatf("spot_run%0d_tile_missing", run), 64'(ntiles[d]), 64'(spots[i].tile + 1));
    end
    foreach (metas[i]) if (metas[i].run == run && metas[i].tile < ntiles[d]) begin
      check($sformatf("meta_run%0d_t%0d_fb", run, metas[i].tile), 64'(tfb[d][metas[i].tile]), 64'(metas[i].fb));
      check($sformatf("meta_run%0d_t%0d_eb", run, metas[i].tile), 64'(teb[d][metas[i].tile]), 64'(metas[i].eb));
      check($sformatf("meta_run%0d_t%0d_last", run, metas[i].tile), 64'(tlast[d][metas[i].tile]), 64'(metas[i].last));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [TW-1:0] snap;
    int zk [2];
    int zf [2];

    // run 1: K=3 F=3 base 0; run 2: F=4; run 3: latency 3, K=2 F=2 base 0x7FFE
    spots.push_back('{1, 0, 0, 0, 1});   spots.push_back('{1, 0, 0, 1, 10});
    spots.push_back('{1, 0, 0, 2, 19});  spots.push_back('{1, 2, 2, 0, 9});
    spots.push_back('{1, 2, 2, 1, 18});  spots.push_back('{1, 2, 2, 2, 27});
    spots.push_back('{2, 3, 0, 0, 28});  spots.push_back('{2, 3, 0, 1, 0});
    spots.push_back('{2, 3, 0, 2, 0});   spots.push_back('{2, 5, 2, 0, 36});
    spots.push_back('{2, 5, 2, 2, 0});
    spots.push_back('{3, 0, 0, 0, 32767}); spots.push_back('{3, 0, 1, 0, 32768});
    spots.push_back('{3, 0, 2, 0, 1});     spots.push_back('{3, 0, 0, 1, 3});
    spots.push_back('{3, 0, 2, 1, 5});     spots.push_back('{3, 0, 0, 2, 0});
    spots.push_back('{3, 1, 0, 0, 2});     spots.push_back('{3, 1, 0, 1, 6});
    spots.push_back('{3, 1, 1, 0, 0});     spots.push_back('{3, 1, 2, 1, 0});
    metas.push_back('{1, 0, 0, 0, 0}); metas.push_back('{1, 1, 0, 3, 0}); metas.push_back('{1, 2, 0, 6, 1});
    metas.push_back('{2, 3, 3, 0, 0}); metas.push_back('{2, 5, 3, 6, 1});
    metas.push_back('{3, 0, 0, 0, 0}); metas.push_back('{3, 1, 0, 3, 1});
    zk[0] = 0; zf[0] = 3;
    zk[1] = 3; zf[1] = 0;
    clear_counts(0);
    clear_counts(1);

    // Reset state
    reset = 1'b0;
    repeat (3) tick();
    check("rst_tile_valid", 64'(valid_a), 64'd0);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_mem_en", 64'(mem_en_a), 64'd0);
    check("rst_mem_addr", 64'(mem_addr_a), 64'd0);
    check("rst_tile_zero", 64'(tile_a === '0), 64'd1);
    check("rst_tile_last", 64'(last_a), 64'd0);
    reset = 1'b1;
    tick();

    // Three tiles, K=3 F=3
    start_load(0, 0, 3, 3);
    wait_done(0, 300);
    check("f3_first_valid_cycle", 64'(fv[0]), 64'd12);
    check_tiles(0, "f3", 0, 3, 3);
    apply_table(1, 0);

    // Six tiles, F=4 exercising padded filter columns
    start_load(0, 0, 3, 4);
    wait_done(0, 400);
    check_tiles(0, "f4", 0, 3, 4);
    apply_table(2, 0);

    // Backpressure on the first tile
    ready_a = 1'b0;
    start_load(0, 0, 3, 3);
    for (int i = 0; i < 100 && !valid_a; i++) tick();
    check("bp_valid_seen", 64'(valid_a), 64'd1);
    snap = tile_a;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold_valid_%0d", i), 64'(valid_a), 64'd1);
      check($sformatf("bp_hold_tile_%0d", i), 64'(tile_a === snap), 64'd1);
      check($sformatf("bp_hold_mem_en_%0d", i), 64'(mem_en_a), 64'd0);
      tick();
    end
    check("bp_no_early_advance", 64'(ntiles[0]), 64'd0);
    ready_a = 1'b1;
    tick();
    check("bp_one_tile_taken", 64'(ntiles[0]), 64'd1);
    check("bp_valid_dropped", 64'(valid_a), 64'd0);
    wait_done(0, 300);
    check_tiles(0, "bp", 0, 3, 3);

    // Empty loads: K=0 and F=0
    for (int z = 0; z < 2; z++) begin
      start_load(0, 0, zk[z], zf[z]);
      check($sformatf("empty%0d_busy_1st", z), 64'(busy_a), 64'd1);
      check($sformatf("empty%0d_done_1st", z), 64'(done_a), 64'd1);
      tick();
      check($sformatf("empty%0d_busy_2nd", z), 64'(busy_a), 64'd0);
      check($sformatf("empty%0d_done_2nd", z), 64'(done_a), 64'd0);
      repeat (3) tick();
      check($sformatf("empty%0d_done_pulses", z), 64'(ndone[0]), 64'd1);
      check($sformatf("empty%0d_reads", z), 64'(nreads[0]), 64'd0);
      check($sformatf("empty%0d_valid_cycles", z), 64'(nvalid[0]), 64'd0);
    end

    // Reset during FETCH of tile 1, then restart
    start_load(0, 0, 3, 3);
    for (int i = 0; i < 100 && ntiles[0] < 1; i++) tick();
    check("abort_tile0_taken", 64'(ntiles[0]), 64'd1);
    repeat (4) tick();
    reset = 1'b0;
    tick();
    check("abort_valid", 64'(valid_a), 64'd0);
    check("abort_busy", 64'(busy_a), 64'd0);
    check("abort_mem_en", 64'(mem_en_a), 64'd0);
    check("abort_tile_zero", 64'(tile_a === '0), 64'd1);
    check("abort_fbase", 64'(fb_a), 64'd0);
    reset = 1'b1;
    repeat (3) tick();
    check("abort_no_done", 64'(ndone[0]), 64'd0);
    start_load(0, 0, 3, 3);
    wait_done(0, 300);
    check("restart_first_valid_cycle", 64'(fv[0]), 64'd12);
    check_tiles(0, "restart", 0, 3, 3);

    // Latency 3 with address wrap
    start_load(1, 32766, 2, 2);
    wait_done(1, 300);
    check("rl3_first_valid_cycle", 64'(fv[1]), 64'd14);
    check_tiles(1, "rl3", 32766, 2, 2);
    apply_table(3, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
